// File: rtl/ucsbece154b_perf_pkg.sv
// Shared types and constants for the superscalar performance monitor.
package ucsbece154b_perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } perf_state_e;

    localparam logic [2:0] SEL_CYC      = 3'd0;
    localparam logic [2:0] SEL_INSTR    = 3'd1;
    localparam logic [2:0] SEL_BRANCH   = 3'd2;
    localparam logic [2:0] SEL_BR_MISS  = 3'd3;
    localparam logic [2:0] SEL_JUMP     = 3'd4;
    localparam logic [2:0] SEL_JMP_MISS = 3'd5;
    localparam logic [2:0] SEL_BUBBLE   = 3'd6;
    localparam logic [2:0] SEL_STATUS   = 3'd7;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    // Lane masks are zero-extended to 4 bits, the widest supported issue width.
    function automatic logic [2:0] popcount(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter; sat pulses in any enabled cycle whose sum would wrap.
module ucsbece154b_sat_counter #(
    parameter int unsigned W     = 32,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     q,
    output logic             sat
);

    logic [W-1:0] r_q;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_q} + (W+1)'(inc);
    assign sat   = en & w_sum[W];
    assign q     = r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_sum[W] ? '1 : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/ucsbece154b_perf_monitor.sv
// Per-lane event counters, NOP self-loop halt detector and counter read mux
// for the N-lane superscalar core.
module ucsbece154b_perf_monitor
    import ucsbece154b_perf_pkg::*;
#(
    parameter int unsigned LANES      = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned IDLE_LIMIT = 2,
    parameter logic [31:0] NOP_INSN   = NOP_ENC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic [LANES-1:0]    issue_valid_i,
    input  logic [LANES-1:0]    br_i,
    input  logic [LANES-1:0]    br_miss_i,
    input  logic [LANES-1:0]    jmp_i,
    input  logic [LANES-1:0]    jmp_miss_i,
    input  logic [32*LANES-1:0] pcf_i,
    input  logic [32*LANES-1:0] instrf_i,
    input  logic [2:0]          rd_sel_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                running_o,
    output logic                done_o,
    output logic                overflow_o
);

    localparam int unsigned INC_W  = $clog2(LANES + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);
    localparam int unsigned STAT_W = 3 + IDLE_W;

    perf_state_e         r_state;
    logic [32*LANES-1:0] r_prev_pc;
    logic                r_prev_valid;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic                r_overflow;

    logic                w_cnt_en;
    logic [INC_W-1:0]    w_inc [7];
    logic [CNT_W-1:0]    w_cnt [7];
    logic [6:0]          w_sat;
    logic [LANES-1:0]    w_lane_idle;
    logic                w_all_idle;
    logic [IDLE_W-1:0]   w_idle_nxt;
    logic                w_halt;
    logic [STAT_W-1:0]   w_status;
    logic [CNT_W-1:0]    w_rd;

    assign w_cnt_en = (r_state == RUN) && !clear_i;

    assign w_inc[0] = INC_W'(1);
    assign w_inc[1] = INC_W'(popcount(4'(issue_valid_i)));
    assign w_inc[2] = INC_W'(popcount(4'(br_i)));
    assign w_inc[3] = INC_W'(popcount(4'(br_i & br_miss_i)));
    assign w_inc[4] = INC_W'(popcount(4'(jmp_i)));
    assign w_inc[5] = INC_W'(popcount(4'(jmp_i & jmp_miss_i)));
    assign w_inc[6] = INC_W'(issue_valid_i == '0);

    for (genvar i = 0; i < 7; i++) begin : g_cnt
        ucsbece154b_sat_counter #(
            .W     (CNT_W),
            .INC_W (INC_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clear_i),
            .en    (w_cnt_en),
            .inc   (w_inc[i]),
            .q     (w_cnt[i]),
            .sat   (w_sat[i])
        );
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_idle[k] = (pcf_i[32*k +: 32] == r_prev_pc[32*k +: 32]) &&
                                (instrf_i[32*k +: 32] == NOP_INSN);
    end

    assign w_all_idle = r_prev_valid && (&w_lane_idle);
    assign w_idle_nxt = r_idle_cnt + IDLE_W'(1);
    assign w_halt     = w_all_idle && (w_idle_nxt == IDLE_W'(IDLE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_idle_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else if (clear_i) begin
            r_state      <= IDLE;
            r_prev_valid <= 1'b0;
            r_idle_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (|w_sat) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_prev_pc  <= pcf_i;
                    r_idle_cnt <= w_all_idle ? w_idle_nxt : '0;
                    // Leaving RUN drops prev_valid so stale PCs never count as a self-loop.
                    if (w_halt) begin
                        r_state      <= HALTED;
                        r_prev_valid <= 1'b0;
                    end else if (!enable_i) begin
                        r_state      <= IDLE;
                        r_prev_valid <= 1'b0;
                    end else begin
                        r_prev_valid <= 1'b1;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_status = {r_state, r_overflow, r_idle_cnt};

    always_comb begin
        w_rd = '0;
        case (rd_sel_i)
            SEL_CYC:      w_rd = w_cnt[0];
            SEL_INSTR:    w_rd = w_cnt[1];
            SEL_BRANCH:   w_rd = w_cnt[2];
            SEL_BR_MISS:  w_rd = w_cnt[3];
            SEL_JUMP:     w_rd = w_cnt[4];
            SEL_JMP_MISS: w_rd = w_cnt[5];
            SEL_BUBBLE:   w_rd = w_cnt[6];
            SEL_STATUS:   w_rd = CNT_W'(w_status);
            default:      w_rd = '0;
        endcase
    end

    assign rd_data_o  = w_rd;
    assign running_o  = (r_state == RUN);
    assign done_o     = (r_state == HALTED);
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_ucsbece154b_perf_monitor.sv
// Directed bench: a 32-bit monitor and a 4-bit monitor share one stimulus stream.
module tb_ucsbece154b_perf_monitor;
    import ucsbece154b_perf_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [1:0]  issue_valid_i = '0;
    logic [1:0]  br_i = '0;
    logic [1:0]  br_miss_i = '0;
    logic [1:0]  jmp_i = '0;
    logic [1:0]  jmp_miss_i = '0;
    logic [63:0] pcf_i = '0;
    logic [63:0] instrf_i = '0;
    logic [2:0]  rd_sel_i = '0;

    logic [31:0] rd_data;
    logic        running, done, ovf;
    logic [3:0]  s_rd;
    logic        s_running, s_done, s_ovf;

    int n_vec = 0;
    int n_miss = 0;
    logic seen_done;

    always #5 clk = ~clk;

    ucsbece154b_perf_monitor #(
        .LANES (2), .CNT_W (32), .IDLE_LIMIT (2), .NOP_INSN (32'h0000_0013)
    ) u_dut (
        .clk (clk), .reset (reset), .enable_i (enable_i), .clear_i (clear_i),
        .issue_valid_i (issue_valid_i), .br_i (br_i), .br_miss_i (br_miss_i),
        .jmp_i (jmp_i), .jmp_miss_i (jmp_miss_i), .pcf_i (pcf_i), .instrf_i (instrf_i),
        .rd_sel_i (rd_sel_i), .rd_data_o (rd_data), .running_o (running),
        .done_o (done), .overflow_o (ovf)
    );

    ucsbece154b_perf_monitor #(
        .LANES (2), .CNT_W (4), .IDLE_LIMIT (2), .NOP_INSN (32'h0000_0013)
    ) u_small (
        .clk (clk), .reset (reset), .enable_i (enable_i), .clear_i (clear_i),
        .issue_valid_i (issue_valid_i), .br_i (br_i), .br_miss_i (br_miss_i),
        .jmp_i (jmp_i), .jmp_miss_i (jmp_miss_i), .pcf_i (pcf_i), .instrf_i (instrf_i),
        .rd_sel_i (rd_sel_i), .rd_data_o (s_rd), .running_o (s_running),
        .done_o (s_done), .overflow_o (s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        rd_sel_i = sel;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic small_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        rd_sel_i = sel;
        #1;
        chk(tag, 32'(s_rd), exp);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);
        rd_chk("rst_cycles", SEL_CYC, 32'd0);
        rd_chk("rst_status", SEL_STATUS, 32'd0);
        reset = 1'b1;
        tick();

        // Both lanes issue for 10 RUN cycles
        issue_valid_i = 2'b11;
        enable_i = 1'b1;
        tick();
        chk("t1_running", 32'(running), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                enable_i = 1'b0;
                chk("t1_running_hold", 32'(running), 32'd1);
            end
            tick();
        end
        chk("t1_running_fell", 32'(running), 32'd0);
        rd_chk("t1_cycles", SEL_CYC, 32'd10);
        rd_chk("t1_instr", SEL_INSTR, 32'd20);
        rd_chk("t1_bubble", SEL_BUBBLE, 32'd0);
        issue_valid_i = '0;

        // Branch/jump accounting; unqualified miss bits ignored
        do_clear();
        enable_i = 1'b1;
        tick();
        br_i = 2'b11;
        br_miss_i = 2'b01;
        repeat (4) tick();
        br_i = '0;
        br_miss_i = '0;
        jmp_miss_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) enable_i = 1'b0;
            tick();
        end
        jmp_miss_i = '0;
        rd_chk("t2_branch", SEL_BRANCH, 32'd8);
        rd_chk("t2_br_miss", SEL_BR_MISS, 32'd4);
        rd_chk("t2_jump", SEL_JUMP, 32'd0);
        rd_chk("t2_jmp_miss", SEL_JMP_MISS, 32'd0);
        rd_chk("t2_cycles", SEL_CYC, 32'd7);
        rd_chk("t2_bubble", SEL_BUBBLE, 32'd7);

        // Both lanes self-loop on NOP: prime + 2 idle cycles then halt
        do_clear();
        enable_i = 1'b1;
        tick();
        pcf_i = {32'h0000_0044, 32'h0000_0040};
        instrf_i = {32'h0000_0013, 32'h0000_0013};
        tick();
        chk("t3_done_c1", 32'(done), 32'd0);
        tick();
        chk("t3_done_c2", 32'(done), 32'd0);
        tick();
        chk("t3_done_c3", 32'(done), 32'd1);
        chk("t3_running", 32'(running), 32'd0);
        rd_chk("t3_status", SEL_STATUS, 32'h12);
        repeat (5) tick();
        rd_chk("t3_cycles_frozen", SEL_CYC, 32'd3);

        // Only lane 0 self-loops; lane 1 advances
        do_clear();
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            pcf_i = {32'h0000_0100 + 32'(4 * i), 32'h0000_0080};
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("t4_never_done", 32'(seen_done), 32'd0);
        rd_chk("t4_status", SEL_STATUS, 32'h08);
        enable_i = 1'b0;
        pcf_i = '0;
        instrf_i = '0;
        tick();

        // Saturation in the 4-bit monitor
        do_clear();
        issue_valid_i = 2'b11;
        enable_i = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 19) enable_i = 1'b0;
            tick();
        end
        issue_valid_i = '0;
        small_chk("t5_s_cycles", SEL_CYC, 32'd15);
        small_chk("t5_s_instr", SEL_INSTR, 32'd15);
        chk("t5_s_overflow", 32'(s_ovf), 32'd1);
        chk("t5_overflow", 32'(ovf), 32'd0);
        rd_chk("t5_cycles", SEL_CYC, 32'd20);
        rd_chk("t5_instr", SEL_INSTR, 32'd40);
        do_clear();
        chk("t5_s_overflow_clr", 32'(s_ovf), 32'd0);
        for (int s = 0; s < 7; s++) begin
            small_chk("t5_s_cleared", 3'(s), 32'd0);
        end
        small_chk("t5_s_status_clr", SEL_STATUS, 32'd0);

        // Asynchronous reset mid-RUN
        enable_i = 1'b1;
        tick();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_running", 32'(running), 32'd0);
        rd_chk("t6_rst_cycles", SEL_CYC, 32'd0);
        reset = 1'b1;
        tick();
        repeat (2) tick();
        chk("t6_rerun", 32'(running), 32'd1);

        // clear_i beats enable_i; nothing counted in the clearing cycle
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        enable_i = 1'b0;
        chk("t6_clr_running", 32'(running), 32'd0);
        rd_chk("t6_clr_cycles", SEL_CYC, 32'd0);
        tick();
        rd_chk("t6_clr_status", SEL_STATUS, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_perf_monitor.md
Name: ucsbece154b_perf_monitor

Overview:
- Synthesizable performance monitor for the N-lane superscalar RISC-V core; sits beside the datapath and taps issue, branch and fetch signals.
- Counts cycles, retired/issued instructions, branches, jumps and mispredictions per lane, plus bubble cycles.
- Detects program completion: every lane self-loops on a NOP.
- Exposes counters through a combinational read mux, so CPI/misprediction data is available on silicon, not only in simulation.

Parameters:
- LANES, 2, issue width; number of lanes monitored (1..4).
- CNT_W, 32, width of every counter.
- IDLE_LIMIT, 2, consecutive all-lane NOP self-loop cycles required to declare halt (>=1).
- NOP_INSN, 32'h00000013, encoding treated as the halt NOP.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  start counting (level).
- clear_i  in  1  synchronous clear of counters and state.
- issue_valid_i  in  LANES  lane k issued a real instruction in E this cycle.
- br_i  in  LANES  lane k resolved a conditional branch in E.
- br_miss_i  in  LANES  lane k branch mispredicted (qualified by br_i).
- jmp_i  in  LANES  lane k resolved jal/jalr in E.
- jmp_miss_i  in  LANES  lane k jump was not predicted taken (qualified by jmp_i).
- pcf_i  in  32*LANES  fetch PC per lane, lane 0 in LSBs.
- instrf_i  in  32*LANES  fetched instruction per lane.
- rd_sel_i  in  3  counter select.
- rd_data_o  out  CNT_W  selected counter value.
- running_o  out  1  state==RUN.
- done_o  out  1  state==HALTED.
- overflow_o  out  1  sticky: some counter saturated.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, prev-PC regs 0, prev_valid 0, idle_cnt 0. Outputs: rd_data_o=0, running_o=0, done_o=0, overflow_o=0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE->RUN when enable_i=1.
  - RUN->HALTED when idle_cnt would reach IDLE_LIMIT.
  - RUN->IDLE when enable_i=0 (pause; counters hold).
  - HALTED holds until clear_i.
- clear_i=1 (synchronous, any state): next state IDLE; all counters, overflow, idle_cnt and prev_valid cleared. clear_i beats enable_i in the same cycle.
- Counting occurs only in cycles where the state is RUN. The halt-detection cycle itself counts. Updates land at the clock edge and are visible on rd_data_o the following cycle.
- Counters and per-cycle increments:
  - cycles +1.
  - instr +popcount(issue_valid_i).
  - branch +popcount(br_i).
  - br_miss +popcount(br_i & br_miss_i).
  - jump +popcount(jmp_i).
  - jmp_miss +popcount(jmp_i & jmp_miss_i).
  - bubble +1 if issue_valid_i==0.
- Miss bits without their qualifier are ignored.
- Saturation: if count+inc exceeds 2^CNT_W-1, the counter holds all-ones and overflow_o sets (sticky until clear/reset). Increments use width clog2(LANES+1); the sum is computed at CNT_W+1 bits.
- Halt detection:
  - prev PC per lane is registered every RUN cycle; prev_valid goes 1 after the first RUN cycle.
  - A cycle is idle if prev_valid=1 and, for every lane, pcf==prev_pc and instrf==NOP_INSN.
  - Idle cycle: idle_cnt+1. Any non-idle cycle: idle_cnt=0.
  - When idle_cnt+1==IDLE_LIMIT, go to HALTED.
  - prev_valid clears on leaving RUN, so a pause does not carry stale PCs.
- Read mux (combinational), rd_sel_i:
  - 0 cycles, 1 instr, 2 branch, 3 br_miss, 4 jump, 5 jmp_miss, 6 bubble.
  - 7 status = {state[1:0], overflow, idle_cnt[...]} zero-extended.
- Reset mid-RUN: immediate return to the reset values above.

Decomposition:
- Package ucsbece154b_perf_pkg:
  - State enum IDLE=2'd0, RUN=2'd1, HALTED=2'd2.
  - Selector constants SEL_CYC..SEL_STATUS.
  - NOP encoding constant.
- Sub-module ucsbece154b_sat_counter:
  - Parameters W, INC_W.
  - Ports: clk, reset, clr, en, inc, q, sat.
  - Instantiated 7 times.
- Popcount is a function in the package.

Test Plan:
- Reset then enable 10 cycles, issue_valid=2'b11 every cycle, disable: cycles=10, instr=20, bubble=0, running_o falls one cycle after enable drops.
- Lane0 br=1/miss=1 and lane1 br=1/miss=0 for 4 cycles; jmp_miss=1 with jmp=0 for 3 cycles: branch=8, br_miss=4, jump=0, jmp_miss=0.
- Both lanes hold pcf=0x40/0x44 with NOP, IDLE_LIMIT=2: done_o rises exactly 3 cycles after the first such fetch (prime + 2 idle); counters then freeze.
- Only lane 0 self-looping on NOP while lane 1 advances: done_o never asserts over 50 cycles; idle_cnt stays 0.
- CNT_W=4, 20 RUN cycles with both lanes issuing: cycles=15, instr=15, overflow_o=1. clear_i: all zero, overflow_o=0.
- Assert reset mid-RUN, and assert clear_i together with enable_i: state IDLE, counters 0, no count in that cycle.
